prof_sample_scheduler: RTL and testbench

//  Shares one perf-counter profiler sink between NUM_CORES cores. A free-running interval timer requests

---
 rtl/prof_pkg.sv | 19 +
 rtl/prof_rr_arbiter.sv | 28 ++
 rtl/prof_sample_scheduler.sv | 138 +++++++++++++
 tb/tb_prof_sample_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prof_pkg.sv
// Shared constants and types for the profiler sample scheduler.
// The counter index constants name the slots within one core's counter bundle.
package prof_pkg;

  localparam int NUM_CTRS_DEFAULT = 5;

  localparam int CTR_INST_RETIRED = 0;
  localparam int CTR_CYCLES       = 1;
  localparam int CTR_DECODED      = 2;
  localparam int CTR_ELIGIBLE     = 3;
  localparam int CTR_ISSUED       = 4;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND
  } state_e;

endpackage

// File: rtl/prof_rr_arbiter.sv
// Round-robin pick: the first requesting core at or after rr_ptr, wrapping past the last core.
module prof_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] grant,
  output logic          any
);

  int idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    // scan farthest-first so the requester nearest rr_ptr overwrites the others
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N;
      if (req[idx]) begin
        grant = IW'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prof_sample_scheduler.sv
// Shares one profiler sink between cores: a periodic timer raises snapshot requests, and a
// round-robin FSM captures one core's counter bundle at a time onto a valid/ready port.
//
// state   | meaning
// IDLE    | waiting for any pending/final request; grants the next core round-robin
// CAPTURE | latches the granted core's counters and its final flag
// SEND    | out_valid high, outputs frozen until out_ready
module prof_sample_scheduler
  import prof_pkg::*;
#(
  parameter int NUM_CORES       = 4,
  parameter int NUM_CTRS        = NUM_CTRS_DEFAULT,
  parameter int COUNTER_WIDTH   = 64,
  parameter int SAMPLE_INTERVAL = 1024,
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic [NUM_CORES-1:0]                        core_finished,
  input  logic [NUM_CORES*NUM_CTRS*COUNTER_WIDTH-1:0] core_counters,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [IW-1:0]                               out_core_id,
  output logic [NUM_CTRS*COUNTER_WIDTH-1:0]           out_counters,
  output logic                                        out_finished,
  output logic [15:0]                                 out_seq,
  output logic [15:0]                                 overrun_count,
  output logic                                        all_done
);

  localparam int BW = NUM_CTRS * COUNTER_WIDTH;
  localparam int TW = $clog2(SAMPLE_INTERVAL);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_INTERVAL - 1);

  state_e               state_q, state_n;
  logic [TW-1:0]        timer_q;
  logic                 tick, hs;
  logic [NUM_CORES-1:0] pending_q, final_pending_q, done_mask_q;
  logic [NUM_CORES-1:0] req, clr, tick_set, fin_set, overrun_hit;
  logic [IW-1:0]        rr_ptr_q, arb_grant, rr_next;
  logic                 arb_any;
  logic [16:0]          overrun_sum;
  logic [15:0]          overrun_next;

  assign tick    = enable && (timer_q == TIMER_LAST);
  assign req     = pending_q | final_pending_q;
  assign rr_next = (out_core_id == IW'(NUM_CORES - 1)) ? '0 : out_core_id + 1'b1;

  prof_rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_grant),
    .any    (arb_any)
  );

  // A tick coinciding with a final handshake must not revive a core that is about to retire.
  always_comb begin
    clr         = '0;
    tick_set    = '0;
    fin_set     = '0;
    overrun_hit = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      clr[i]         = hs && (int'(out_core_id) == i);
      tick_set[i]    = tick && !done_mask_q[i] && !(clr[i] && out_finished);
      overrun_hit[i] = tick && !done_mask_q[i] && pending_q[i] && !clr[i];
      fin_set[i]     = core_finished[i] && !done_mask_q[i] && !final_pending_q[i];
    end
  end

  always_comb begin
    overrun_sum = {1'b0, overrun_count};
    for (int i = 0; i < NUM_CORES; i++) begin
      overrun_sum = overrun_sum + 17'(overrun_hit[i]);
    end
    overrun_next = overrun_sum[16] ? 16'hFFFF : overrun_sum[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q         <= '0;
      pending_q       <= '0;
      final_pending_q <= '0;
      done_mask_q     <= '0;
      all_done        <= 1'b0;
      overrun_count   <= '0;
    end else begin
      timer_q         <= (!enable || timer_q == TIMER_LAST) ? '0 : timer_q + 1'b1;
      pending_q       <= (pending_q & ~clr) | tick_set;
      final_pending_q <= (final_pending_q & ~(clr & {NUM_CORES{out_finished}})) | fin_set;
      done_mask_q     <= done_mask_q | (clr & {NUM_CORES{out_finished}});
      all_done        <= &done_mask_q;
      overrun_count   <= overrun_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    out_valid = 1'b0;
    hs        = 1'b0;
    case (state_q)
      IDLE:    if (arb_any) state_n = CAPTURE;
      CAPTURE: state_n = SEND;
      SEND: begin
        out_valid = 1'b1;
        hs        = out_ready;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      out_core_id  <= '0;
      out_counters <= '0;
      out_finished <= 1'b0;
      out_seq      <= '0;
    end else begin
      if (state_q == IDLE && arb_any) out_core_id <= arb_grant;
      if (state_q == CAPTURE) begin
        out_counters <= core_counters[int'(out_core_id) * BW +: BW];
        out_finished <= final_pending_q[out_core_id];
      end
      if (hs) begin
        rr_ptr_q <= rr_next;
        out_seq  <= out_seq + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_prof_sample_scheduler.sv
// Scenario bench for prof_sample_scheduler: expected samples are queued as stimulus is set up
// and checked in order by a scoreboard process as handshakes complete.
module tb_prof_sample_scheduler;

  localparam int NC = 4;
  localparam int NT = 5;
  localparam int CW = 32;
  localparam int SI = 8;
  localparam int BW = NT * CW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          out_ready = 1'b0;
  logic [NC-1:0] core_finished = '0;
  logic [NC*BW-1:0] core_counters;
  logic          out_valid;
  logic [1:0]    out_core_id;
  logic [BW-1:0] out_counters;
  logic          out_finished;
  logic [15:0]   out_seq;
  logic [15:0]   overrun_count;
  logic          all_done;
  logic [15:0]   salt = 16'h0;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int            core;
    logic          fin;
    int            seq;
    logic [BW-1:0] ctrs;
  } exp_t;
  exp_t sb[$];

  prof_sample_scheduler #(
    .NUM_CORES(NC), .NUM_CTRS(NT), .COUNTER_WIDTH(CW), .SAMPLE_INTERVAL(SI)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .core_finished(core_finished),
    .core_counters(core_counters), .out_valid(out_valid), .out_ready(out_ready),
    .out_core_id(out_core_id), .out_counters(out_counters), .out_finished(out_finished),
    .out_seq(out_seq), .overrun_count(overrun_count), .all_done(all_done)
  );

  always #5 clock = ~clock;

  // cycle k is the interval after the k-th rising edge following reset release
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  function automatic logic [BW-1:0] bundle(int c, logic [15:0] s);
    logic [BW-1:0] r;
    r = '0;
    for (int t = 0; t < NT; t++) r[t*CW +: CW] = {8'(c), 8'(t), s};
    return r;
  endfunction

  always_comb begin
    core_counters = '0;
    for (int c = 0; c < NC; c++) core_counters[c*BW +: BW] = bundle(c, salt);
  end

  function automatic exp_t mk(int c, logic f, int s, logic [15:0] sl);
    exp_t e;
    e.core = c; e.fin = f; e.seq = s; e.ctrs = bundle(c, sl);
    return e;
  endfunction

  task automatic to_cycle(int k);
    while (cyc < k) begin @(posedge clock); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; core_finished = '0;
    sb.delete();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_drain(int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) begin ok = 1'b1; break; end
      @(posedge clock); #1;
    end
  endtask

  task automatic monitor_scoreboard();
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_sample: got core %0d seq %0d at cycle %0d, want no sample", out_core_id, out_seq, cyc);
        end else begin
          e = sb.pop_front();
          if (out_core_id !== 2'(e.core)) begin
            fails++; $display("FAIL sample_core: got %0d, want %0d", out_core_id, e.core);
          end
          tests++;
          if (out_finished !== e.fin) begin
            fails++; $display("FAIL sample_finished: core %0d got %0b, want %0b", e.core, out_finished, e.fin);
          end
          tests++;
          if (out_seq !== 16'(e.seq)) begin
            fails++; $display("FAIL sample_seq: got %0d, want %0d", out_seq, e.seq);
          end
          tests++;
          if (out_counters !== e.ctrs) begin
            fails++; $display("FAIL sample_counters: core %0d got %h, want %h", e.core, out_counters, e.ctrs);
          end
        end
      end
    end
  endtask

  task automatic watchdog();
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1; core_finished = '1; salt = 16'hABCD;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests++;
    if (out_valid !== 1'b0 || out_finished !== 1'b0 || all_done !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got valid %b fin %b done %b, want 0 0 0", out_valid, out_finished, all_done);
    end
    tests++;
    if (out_seq !== 16'd0 || overrun_count !== 16'd0 || out_core_id !== 2'd0) begin
      fails++; $display("FAIL reset_counts: got seq %0d ovr %0d id %0d, want 0 0 0", out_seq, overrun_count, out_core_id);
    end
    tests++;
    if (out_counters !== '0) begin
      fails++; $display("FAIL reset_counters: got %h, want 0", out_counters);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int first;
    do_reset();
    salt = 16'h1111; enable = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < NC; c++) sb.push_back(mk(c, 1'b0, c, 16'h1111));
    first = -1;
    for (int i = 0; i < 40 && first < 0; i++) begin
      @(negedge clock);
      if (out_valid === 1'b1) first = cyc;
    end
    tests++;
    if (first != 10) begin
      fails++; $display("FAIL first_valid_cycle: got %0d, want 10", first);
    end
    wait_drain(40, ok);
    out_ready = 1'b0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL rr_drain: got %0d samples outstanding, want 0", sb.size());
    end
    @(negedge clock);
    tests++;
    if (overrun_count !== 16'd2) begin
      fails++; $display("FAIL rr_overrun: got %0d, want 2", overrun_count);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    salt = 16'h2222; enable = 1'b1; out_ready = 1'b0;
    sb.push_back(mk(0, 1'b0, 0, 16'h2222));
    sb.push_back(mk(1, 1'b0, 1, 16'h2A2A));
    for (int k = 10; k <= 47; k++) begin
      to_cycle(k);
      if (k == 20) salt = 16'h2A2A;
      @(negedge clock);
      tests++;
      if (out_valid !== 1'b1 || out_core_id !== 2'd0 || out_counters !== bundle(0, 16'h2222)) begin
        fails++;
        $display("FAIL hold_stable: cycle %0d got valid %b id %0d ctrs %h, want 1 0 %h", k, out_valid, out_core_id, out_counters, bundle(0, 16'h2222));
      end
    end
    tests++;
    if (overrun_count !== 16'd16) begin
      fails++; $display("FAIL hold_overrun: got %0d, want 16", overrun_count);
    end
    to_cycle(48);
    out_ready = 1'b1;
    @(negedge clock);
    tests++;
    if (overrun_count !== 16'd20) begin
      fails++; $display("FAIL release_overrun: got %0d, want 20", overrun_count);
    end
    wait_drain(40, ok);
    out_ready = 1'b0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL bp_drain: got %0d samples outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_finish_single();
    bit ok;
    do_reset();
    salt = 16'h3333; enable = 1'b1; out_ready = 1'b1;
    sb.push_back(mk(2, 1'b1, 0, 16'h3333));
    sb.push_back(mk(3, 1'b0, 1, 16'h3333));
    sb.push_back(mk(0, 1'b0, 2, 16'h3333));
    sb.push_back(mk(1, 1'b0, 3, 16'h3333));
    sb.push_back(mk(3, 1'b0, 4, 16'h3333));
    sb.push_back(mk(0, 1'b0, 5, 16'h3333));
    to_cycle(3);
    core_finished[2] = 1'b1;
    wait_drain(60, ok);
    out_ready = 1'b0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL fin2_drain: got %0d samples outstanding, want 0", sb.size());
    end
    @(negedge clock);
    tests++;
    if (all_done !== 1'b0) begin
      fails++; $display("FAIL fin2_all_done: got %b, want 0", all_done);
    end
  endtask

  task automatic test_all_finish();
    bit ok;
    do_reset();
    salt = 16'h4444; enable = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < NC; c++) sb.push_back(mk(c, 1'b1, c, 16'h4444));
    to_cycle(2);
    core_finished = '1;
    to_cycle(14);
    @(negedge clock);
    tests++;
    if (all_done !== 1'b0) begin
      fails++; $display("FAIL all_done_early: got %b, want 0", all_done);
    end
    to_cycle(16);
    @(negedge clock);
    tests++;
    if (all_done !== 1'b1) begin
      fails++; $display("FAIL all_done_set: got %b, want 1", all_done);
    end
    wait_drain(5, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL all_fin_drain: got %0d samples outstanding, want 0", sb.size());
    end
    enable = 1'b1;
    to_cycle(40);
    @(negedge clock);
    tests++;
    if (all_done !== 1'b1 || overrun_count !== 16'd0) begin
      fails++; $display("FAIL all_done_hold: got done %b ovr %0d, want 1 0", all_done, overrun_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_tick_on_handshake();
    bit ok;
    do_reset();
    salt = 16'h5555; enable = 1'b1; out_ready = 1'b0;
    sb.push_back(mk(0, 1'b0, 0, 16'h5555));
    sb.push_back(mk(1, 1'b0, 1, 16'h5555));
    sb.push_back(mk(2, 1'b0, 2, 16'h5555));
    sb.push_back(mk(3, 1'b0, 3, 16'h5555));
    sb.push_back(mk(0, 1'b0, 4, 16'h5555));
    sb.push_back(mk(1, 1'b0, 5, 16'h5555));
    to_cycle(12);
    out_ready = 1'b1;
    to_cycle(15);
    @(negedge clock);
    tests++;
    if (out_valid !== 1'b1 || out_core_id !== 2'd1) begin
      fails++; $display("FAIL coincide_setup: got valid %b id %0d, want 1 1", out_valid, out_core_id);
    end
    to_cycle(16);
    enable = 1'b0;
    @(negedge clock);
    tests++;
    if (overrun_count !== 16'd2) begin
      fails++; $display("FAIL coincide_overrun: got %0d, want 2", overrun_count);
    end
    wait_drain(60, ok);
    out_ready = 1'b0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL coincide_drain: got %0d samples outstanding, want 0", sb.size());
    end
    tests++;
    if (overrun_count !== 16'd2) begin
      fails++; $display("FAIL coincide_overrun_end: got %0d, want 2", overrun_count);
    end
  endtask

  task automatic test_reset_in_send();
    bit ok;
    do_reset();
    salt = 16'h6666; enable = 1'b1; out_ready = 1'b1;
    sb.push_back(mk(0, 1'b0, 0, 16'h6666));
    to_cycle(13);
    out_ready = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL pre_reset_drain: got %0d samples outstanding, want 0", sb.size());
    end
    to_cycle(14);
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (out_valid !== 1'b1 || out_seq !== 16'd1 || out_core_id !== 2'd1) begin
      fails++; $display("FAIL pre_reset_send: got valid %b seq %0d id %0d, want 1 1 1", out_valid, out_seq, out_core_id);
    end
    @(posedge clock); #1;
    @(negedge clock);
    tests++;
    if (out_valid !== 1'b0 || out_seq !== 16'd0 || out_core_id !== 2'd0) begin
      fails++; $display("FAIL reset_in_send: got valid %b seq %0d id %0d, want 0 0 0", out_valid, out_seq, out_core_id);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    sb.push_back(mk(0, 1'b0, 0, 16'h6666));
    sb.push_back(mk(1, 1'b0, 1, 16'h6666));
    out_ready = 1'b1;
    wait_drain(40, ok);
    out_ready = 1'b0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL post_reset_drain: got %0d samples outstanding, want 0", sb.size());
    end
  endtask

  initial begin
    fork
      monitor_scoreboard();
      watchdog();
    join_none
    test_reset();
    test_round_robin();
    test_backpressure();
    test_finish_single();
    test_all_finish();
    test_tick_on_handshake();
    test_reset_in_send();
    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
